// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of writeback, secondary-result, issue and decode-snoop signals
// shared between the pipeline/long-latency unit and the write-port arbiter.
interface regfile_wb_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              p_we;
  logic [ADDR_W-1:0] p_waddr;
  logic [DATA_W-1:0] p_wdata;

  logic              s_valid;
  logic [ADDR_W-1:0] s_waddr;
  logic [DATA_W-1:0] s_wdata;
  logic              s_ready;

  logic              iss_valid;
  logic [ADDR_W-1:0] iss_waddr;

  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;

  logic              stall_req;
  logic              hold_req;
  logic              collision_err;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  modport master (
    output p_we, p_waddr, p_wdata,
    output s_valid, s_waddr, s_wdata,
    input  s_ready,
    output iss_valid, iss_waddr,
    output re1, raddr1, re2, raddr2,
    input  stall_req, hold_req, collision_err,
    input  we, waddr, wdata
  );

  modport slave (
    input  p_we, p_waddr, p_wdata,
    input  s_valid, s_waddr, s_wdata,
    output s_ready,
    input  iss_valid, iss_waddr,
    input  re1, raddr1, re2, raddr2,
    output stall_req, hold_req, collision_err,
    output we, waddr, wdata
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: primary writeback always wins, secondary
// results queue in a 2-entry FIFO, with anti-starvation hold and busy scoreboard.
module regfile_wb_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int NREG       = 32,
  parameter int STARVE_MAX = 4
) (
  input logic                clk,
  input logic                rst,
  input logic                rdy,
  regfile_wb_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [ADDR_W-1:0] fifo_addr [2];
  logic [DATA_W-1:0] fifo_data [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count;
  logic [CNT_W-1:0]  starve_cnt;
  logic              hold_q;
  logic              coll_q;
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_m;

  logic              empty;
  logic              full;
  logic              s_ready_int;
  logic              stall_int;
  logic              push;
  logic              pop;
  logic              iss_acc;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  assign empty       = (count == 2'd0);
  assign full        = (count == 2'd2);
  assign head_addr   = fifo_addr[rd_ptr];
  assign head_data   = fifo_data[rd_ptr];
  assign s_ready_int = rdy & ~full & ~rst;
  assign push        = bus.s_valid & s_ready_int;
  assign pop         = rdy & ~rst & ~bus.p_we & ~empty;
  assign iss_acc     = rdy & bus.iss_valid & ~stall_int & (bus.iss_waddr != '0);

  assign bus.s_ready       = s_ready_int;
  assign bus.stall_req     = stall_int;
  assign bus.hold_req      = hold_q;
  assign bus.collision_err = coll_q;

  // With rdy low the head is not presented, so we simply mirrors p_we.
  always_comb begin
    bus.we    = 1'b0;
    bus.waddr = '0;
    bus.wdata = '0;
    if (!rst) begin
      if (bus.p_we) begin
        bus.we    = 1'b1;
        bus.waddr = bus.p_waddr;
        bus.wdata = bus.p_wdata;
      end else if (rdy && !empty) begin
        bus.we    = 1'b1;
        bus.waddr = head_addr;
        bus.wdata = head_data;
      end
    end
  end

  // The register being written by a pop this cycle is forwarded by the
  // register file, so it no longer counts as a hazard.
  always_comb begin
    busy_m    = '0;
    stall_int = 1'b0;
    for (int unsigned i = 0; i < NREG; i++) begin
      busy_m[i] = busy[i] & ~(pop && (head_addr == ADDR_W'(i)));
    end
    for (int unsigned i = 0; i < NREG; i++) begin
      if (busy_m[i]) begin
        if (bus.re1 && (bus.raddr1 == ADDR_W'(i)))       stall_int = 1'b1;
        if (bus.re2 && (bus.raddr2 == ADDR_W'(i)))       stall_int = 1'b1;
        if (bus.iss_valid && (bus.iss_waddr == ADDR_W'(i))) stall_int = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_addr[i] <= '0;
        fifo_data[i] <= '0;
      end
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= '0;
      starve_cnt <= '0;
      hold_q     <= 1'b0;
      coll_q     <= 1'b0;
      busy       <= '0;
    end else if (rdy) begin
      if (push) begin
        fifo_addr[wr_ptr] <= bus.s_waddr;
        fifo_data[wr_ptr] <= bus.s_wdata;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};

      // hold rises on the same edge the counter reaches its limit, so the
      // head waits STARVE_MAX lost cycles plus the one hold cycle.
      if (pop) begin
        starve_cnt <= '0;
        hold_q     <= 1'b0;
      end else if (!empty && bus.p_we && (starve_cnt != CNT_W'(STARVE_MAX))) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
        if (starve_cnt == CNT_W'(STARVE_MAX - 1)) hold_q <= 1'b1;
      end

      coll_q <= hold_q & bus.p_we;

      busy[0] <= 1'b0;
      for (int unsigned i = 1; i < NREG; i++) begin
        if (iss_acc && (bus.iss_waddr == ADDR_W'(i)))
          busy[i] <= 1'b1;
        else if (pop && (head_addr == ADDR_W'(i)))
          busy[i] <= 1'b0;
      end
    end else begin
      coll_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter with hand-written
// sequences for ready-freeze and mid-stream reset.
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic rdy;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  regfile_wb_arbiter #(
    .ADDR_W(5), .DATA_W(32), .NREG(32), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .bus(bus)
  );

  typedef struct {
    logic        p_we;
    logic [4:0]  p_waddr;
    logic [31:0] p_wdata;
    logic        s_valid;
    logic [4:0]  s_waddr;
    logic [31:0] s_wdata;
    logic        iss_valid;
    logic [4:0]  iss_waddr;
    logic        re1;
    logic [4:0]  raddr1;
    logic        re2;
    logic [4:0]  raddr2;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        s_ready;
    logic        stall;
    logic        hold;
    logic        coll;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(
    input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
    input logic sv, input logic [4:0] sa, input logic [31:0] sd,
    input logic iv, input logic [4:0] ia,
    input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2,
    input logic xwe, input logic [4:0] xwa, input logic [31:0] xwd,
    input logic xsr, input logic xst, input logic xho, input logic xco);
    vec_t v;
    v.p_we = pwe; v.p_waddr = pa; v.p_wdata = pd;
    v.s_valid = sv; v.s_waddr = sa; v.s_wdata = sd;
    v.iss_valid = iv; v.iss_waddr = ia;
    v.re1 = e1; v.raddr1 = a1; v.re2 = e2; v.raddr2 = a2;
    v.we = xwe; v.waddr = xwa; v.wdata = xwd;
    v.s_ready = xsr; v.stall = xst; v.hold = xho; v.coll = xco;
    return v;
  endfunction

  task automatic chk(input string name, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h, expected %0h", name, id, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic pwe, input logic [4:0] pa,
                       input logic [31:0] pd, input logic sv, input logic [4:0] sa,
                       input logic [31:0] sd, input logic iv, input logic [4:0] ia,
                       input logic e1, input logic [4:0] a1,
                       input logic e2, input logic [4:0] a2);
    rdy = r;
    bus.p_we = pwe; bus.p_waddr = pa; bus.p_wdata = pd;
    bus.s_valid = sv; bus.s_waddr = sa; bus.s_wdata = sd;
    bus.iss_valid = iv; bus.iss_waddr = ia;
    bus.re1 = e1; bus.raddr1 = a1; bus.re2 = e2; bus.raddr2 = a2;
  endtask

  task automatic expect_out(input int id, input logic xwe, input logic [4:0] xwa,
                            input logic [31:0] xwd, input logic xsr, input logic xst,
                            input logic xho, input logic xco);
    chk("we", id, 32'(bus.we), 32'(xwe));
    if (xwe) begin
      chk("waddr", id, 32'(bus.waddr), 32'(xwa));
      chk("wdata", id, bus.wdata, xwd);
    end
    chk("s_ready", id, 32'(bus.s_ready), 32'(xsr));
    chk("stall_req", id, 32'(bus.stall_req), 32'(xst));
    chk("hold_req", id, 32'(bus.hold_req), 32'(xho));
    chk("collision_err", id, 32'(bus.collision_err), 32'(xco));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Issue/read hazard, primary zero latency, WAW, starvation and backpressure.
    tbl.push_back(mk(0,0,0,          0,0,0,           1,7, 0,0,0,0, 0,0,0,           1,0,0,0));
    tbl.push_back(mk(0,0,0,          0,0,0,           0,0, 1,7,0,0, 0,0,0,           1,1,0,0));
    tbl.push_back(mk(0,0,0,          1,7,32'hDEADBEEF,0,0, 1,7,0,0, 0,0,0,           1,1,0,0));
    tbl.push_back(mk(0,0,0,          0,0,0,           0,0, 1,7,0,0, 1,7,32'hDEADBEEF,1,0,0,0));
    tbl.push_back(mk(0,0,0,          0,0,0,           0,0, 1,7,0,0, 0,0,0,           1,0,0,0));
    tbl.push_back(mk(1,9,32'h12345678,0,0,0,          0,0, 0,0,1,0, 1,9,32'h12345678,1,0,0,0));
    tbl.push_back(mk(0,0,0,          0,0,0,           1,3, 0,0,0,0, 0,0,0,           1,0,0,0));
    tbl.push_back(mk(0,0,0,          0,0,0,           1,3, 0,0,0,0, 0,0,0,           1,1,0,0));
    tbl.push_back(mk(0,0,0,          1,3,32'h33,      0,0, 0,0,0,0, 0,0,0,           1,0,0,0));
    tbl.push_back(mk(0,0,0,          0,0,0,           1,3, 0,0,0,0, 1,3,32'h33,      1,0,0,0));
    tbl.push_back(mk(0,0,0,          0,0,0,           0,0, 0,0,1,3, 0,0,0,           1,1,0,0));
    tbl.push_back(mk(1,1,32'h100,    1,10,32'hA0,     0,0, 0,0,0,0, 1,1,32'h100,     1,0,0,0));
    tbl.push_back(mk(1,2,32'h200,    1,11,32'hB0,     0,0, 0,0,0,0, 1,2,32'h200,     1,0,0,0));
    tbl.push_back(mk(1,1,32'h300,    1,12,32'hC0,     0,0, 0,0,0,0, 1,1,32'h300,     0,0,0,0));
    tbl.push_back(mk(1,1,32'h300,    1,12,32'hC0,     0,0, 0,0,0,0, 1,1,32'h300,     0,0,0,0));
    tbl.push_back(mk(1,1,32'h300,    1,12,32'hC0,     0,0, 0,0,0,0, 1,1,32'h300,     0,0,0,0));
    tbl.push_back(mk(1,1,32'h300,    1,12,32'hC0,     0,0, 0,0,0,0, 1,1,32'h300,     0,0,1,0));
    tbl.push_back(mk(0,0,0,          1,12,32'hC0,     0,0, 0,0,0,0, 1,10,32'hA0,     0,0,1,1));
    tbl.push_back(mk(0,0,0,          1,12,32'hC0,     0,0, 0,0,0,0, 1,11,32'hB0,     1,0,0,0));
    tbl.push_back(mk(0,0,0,          0,0,0,           0,0, 0,0,0,0, 1,12,32'hC0,     1,0,0,0));
    tbl.push_back(mk(0,0,0,          0,0,0,           0,0, 0,0,0,0, 0,0,0,           1,0,0,0));

    rst = 1'b1;
    drive(1, 0,0,0, 0,0,0, 0,0, 0,0,0,0);
    #3;
    expect_out(900, 0,0,0, 0,0,0,0);
    next_cycle();
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(1, tbl[i].p_we, tbl[i].p_waddr, tbl[i].p_wdata,
            tbl[i].s_valid, tbl[i].s_waddr, tbl[i].s_wdata,
            tbl[i].iss_valid, tbl[i].iss_waddr,
            tbl[i].re1, tbl[i].raddr1, tbl[i].re2, tbl[i].raddr2);
      #2;
      expect_out(i, tbl[i].we, tbl[i].waddr, tbl[i].wdata,
                 tbl[i].s_ready, tbl[i].stall, tbl[i].hold, tbl[i].coll);
      next_cycle();
    end

    // rdy low for 3 cycles with two entries queued, counter at 2, busy[6] set.
    drive(1, 1,1,32'h1, 1,20,32'h14, 1,6, 0,0,0,0); next_cycle();
    drive(1, 1,1,32'h1, 1,21,32'h15, 0,0, 0,0,0,0); next_cycle();
    drive(1, 1,1,32'h1, 0,0,0,       0,0, 0,0,0,0); next_cycle();
    drive(0, 1,4,32'h44, 1,22,32'h16, 0,0, 1,6,0,0); #2;
    expect_out(100, 1,4,32'h44, 0,1,0,0); next_cycle();
    drive(0, 0,0,0,      1,22,32'h16, 0,0, 1,6,0,0); #2;
    expect_out(101, 0,0,0, 0,1,0,0); next_cycle();
    drive(0, 1,4,32'h44, 1,22,32'h16, 0,0, 1,6,0,0); #2;
    expect_out(102, 1,4,32'h44, 0,1,0,0); next_cycle();
    drive(1, 1,4,32'h44, 1,22,32'h16, 0,0, 1,6,0,0); #2;
    expect_out(103, 1,4,32'h44, 0,1,0,0); next_cycle();
    drive(1, 1,4,32'h44, 1,22,32'h16, 0,0, 1,6,0,0); #2;
    expect_out(104, 1,4,32'h44, 0,1,0,0); next_cycle();
    drive(1, 0,0,0, 0,0,0, 0,0, 1,6,0,0); #2;
    expect_out(105, 1,20,32'h14, 0,1,1,0); next_cycle();
    drive(1, 0,0,0, 0,0,0, 0,0, 1,6,0,0); #2;
    expect_out(106, 1,21,32'h15, 1,1,0,0); next_cycle();
    drive(1, 0,0,0, 0,0,0, 0,0, 1,6,0,0); #2;
    expect_out(107, 0,0,0, 1,1,0,0); next_cycle();

    // Reset mid-stream with two entries queued and busy[5] set.
    drive(1, 1,1,32'h1, 1,25,32'h19, 1,5, 0,0,0,0); #2;
    expect_out(200, 1,1,32'h1, 1,0,0,0); next_cycle();
    drive(1, 1,1,32'h1, 1,26,32'h1A, 0,0, 0,0,0,0); next_cycle();
    rst = 1'b1;
    drive(1, 0,0,0, 1,27,32'h1B, 0,0, 1,5,1,3); #2;
    expect_out(201, 0,0,0, 0,0,0,0); next_cycle();
    rst = 1'b0;
    drive(1, 0,0,0, 0,0,0, 0,0, 1,5,1,6); #2;
    expect_out(202, 0,0,0, 1,0,0,0); next_cycle();
    drive(1, 0,0,0, 0,0,0, 1,5, 0,0,0,0); #2;
    expect_out(203, 0,0,0, 1,0,0,0); next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
